prog_ctr: RTL and testbench

//  Program counter / fetch sequencer downstream of the branch-target LUT.

---
 rtl/prog_ctr.sv | 120 ++++++++++++
 tb/tb_prog_ctr.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ctr.sv
// prog_ctr: program counter / fetch sequencer.
// Runs one program from START_ADDR on a start pulse. Each active cycle the PC
// advances by one, or by the LUT's signed relative target on a taken branch.
// The program ends on a halt request or when the PC reaches HALT_ADDR.
// Optional feature macro: PROG_CTR_BR_CNT_EN adds a saturating taken-branch
// counter output (br_cnt). The default build, with the macro undefined, has
// no counter.
module prog_ctr #(
  parameter int             D          = 12,
  parameter logic [D-1:0]   START_ADDR = '0,
  parameter logic [D-1:0]   HALT_ADDR  = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stall,
  input  logic         branch,
  input  logic [D-1:0] target,
  input  logic         halt_req,
  output logic [D-1:0] pc,
  output logic         running,
`ifdef PROG_CTR_BR_CNT_EN
  output logic [15:0]  br_cnt,
`endif
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t       r_state;
  logic [D-1:0] r_pc;
  logic         r_running;
  logic         r_done;

  logic [D-1:0] w_pc_next;
  logic         w_halt;

  // The HALT_ADDR check uses the registered PC.
  // That instruction therefore spends exactly one cycle in RUN.
  assign w_halt = (halt_req & ~stall) | (r_pc == HALT_ADDR);

  // Next PC for an unstalled RUN cycle.
  // A taken branch adds the two's-complement target, otherwise the PC steps
  // by one. Both cases wrap modulo 2^D.
  always_comb begin
    w_pc_next = r_pc;
    if (branch) begin
      w_pc_next = r_pc + target;
    end else begin
      w_pc_next = r_pc + {{(D-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer FSM: state, PC and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pc      <= START_ADDR;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_pc      <= START_ADDR;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_halt) begin
            r_state   <= ST_HALT;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (!stall) begin
            r_pc <= w_pc_next;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pc      <= START_ADDR;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_CTR_BR_CNT_EN
  logic [15:0] r_br_cnt;
  logic        w_br_taken;

  // A branch counts only on a cycle where it actually moves the PC.
  assign w_br_taken = (r_state == ST_RUN) & branch & ~stall & ~halt_req & ~w_halt;

  // Taken-branch counter.
  // It clears on a honoured start, saturates at all ones, and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt <= 16'h0000;
    end else if ((r_state != ST_RUN) && start) begin
      r_br_cnt <= 16'h0000;
    end else if (w_br_taken && (r_br_cnt != 16'hFFFF)) begin
      r_br_cnt <= r_br_cnt + 16'h0001;
    end
  end

  assign br_cnt = r_br_cnt;
`endif

  assign pc      = r_pc;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_prog_ctr.sv
// Self-checking bench for prog_ctr (D=12, START_ADDR=0, HALT_ADDR=4095).
module tb_prog_ctr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        branch;
  logic [11:0] target;
  logic        halt_req;
  logic [11:0] pc;
  logic        running;
  logic        done;
`ifdef PROG_CTR_BR_CNT_EN
  logic [15:0] br_cnt;
`endif

  int n_pass;
  int n_total;

  prog_ctr #(.D(12), .START_ADDR(12'd0), .HALT_ADDR(12'hFFF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stall    (stall),
    .branch   (branch),
    .target   (target),
    .halt_req (halt_req),
    .pc       (pc),
    .running  (running),
`ifdef PROG_CTR_BR_CNT_EN
    .br_cnt   (br_cnt),
`endif
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a program phase plus an integer PC with modular arithmetic.
  // The phase takes the values "idle", "run" and "done".
  int m_phase;  // 0 idle, 1 running a program, 2 program finished
  int m_pc;
  int m_cnt;

  function automatic int wrap12(input int v);
    return ((v % 4096) + 4096) % 4096;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_pc    <= 0;
      m_cnt   <= 0;
    end else if (m_phase != 1) begin
      if (start) begin
        m_phase <= 1;
        m_pc    <= 0;
        m_cnt   <= 0;
      end
    end else if (m_pc == 4095 || (halt_req && !stall)) begin
      m_phase <= 2;
    end else if (!stall) begin
      if (branch) begin
        m_pc  <= wrap12(m_pc + int'($signed(target)));
        m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
        m_pc <= wrap12(m_pc + 1);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_pc", int'(pc), m_pc);
      check("model_running", int'(running), (m_phase == 1) ? 1 : 0);
      check("model_done", int'(done), (m_phase == 2) ? 1 : 0);
`ifdef PROG_CTR_BR_CNT_EN
      check("model_br_cnt", int'(br_cnt), m_cnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic st, input logic br,
                       input logic [11:0] tg, input logic hr);
    start = s; stall = st; branch = br; target = tg; halt_req = hr;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    check("reset_pc", int'(pc), 0);
    check("reset_running", int'(running), 0);
    check("reset_done", int'(done), 0);

    // start then plain increments
    drive(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    check("start_pc", int'(pc), 0);
    check("start_running", int'(running), 1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("incr_pc", int'(pc), i);
    end

    // backward, forward and self-loop branches
    drive(1'b0, 1'b0, 1'b1, 12'hFFB, 1'b0);
    cyc();
    check("branch_back", int'(pc), 5);
    drive(1'b0, 1'b0, 1'b1, 12'd20, 1'b0);
    cyc();
    check("branch_fwd", int'(pc), 25);
    drive(1'b0, 1'b0, 1'b1, 12'd0, 1'b0);
    cyc();
    cyc();
    check("self_loop_pc", int'(pc), 25);
    check("self_loop_running", int'(running), 1);

    // wrap: 25 - 31 = 4090, then 4090 + 20 = 14
    drive(1'b0, 1'b0, 1'b1, 12'hFE1, 1'b0);
    cyc();
    check("to_4090", int'(pc), 4090);
    drive(1'b0, 1'b0, 1'b1, 12'd20, 1'b0);
    cyc();
    check("wrap_pc", int'(pc), 14);

    // stall dominates branch and halt_req
    drive(1'b0, 1'b1, 1'b1, 12'd7, 1'b0);
    cyc();
    check("stall_branch_pc", int'(pc), 14);
    drive(1'b0, 1'b1, 1'b1, 12'd7, 1'b1);
    cyc();
    check("stall_halt_running", int'(running), 1);
    check("stall_halt_pc", int'(pc), 14);

    // halt_req with branch: halt wins, pc holds
    drive(1'b0, 1'b0, 1'b1, 12'd7, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    check("halt_done", int'(done), 1);
    check("halt_running", int'(running), 0);
    check("halt_pc", int'(pc), 14);
    cyc();
    check("halt_hold_done", int'(done), 1);

    // restart from HALT, then three taken branches around one stalled branch
    drive(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    cyc();
    check("restart_pc", int'(pc), 0);
    check("restart_done", int'(done), 0);
    drive(1'b0, 1'b0, 1'b1, 12'd3, 1'b0);
    cyc();
    cyc();
    drive(1'b0, 1'b1, 1'b1, 12'd3, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 12'd3, 1'b0);
    cyc();
    check("three_branch_pc", int'(pc), 9);
`ifdef PROG_CTR_BR_CNT_EN
    check("br_cnt_three", int'(br_cnt), 3);
`endif

    // reaching HALT_ADDR: one RUN cycle at 4095, then HALT
    drive(1'b0, 1'b0, 1'b1, 12'hFF6, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    check("at_halt_addr_pc", int'(pc), 4095);
    check("at_halt_addr_running", int'(running), 1);
    cyc();
    check("halt_addr_done", int'(done), 1);
    check("halt_addr_pc", int'(pc), 4095);
`ifdef PROG_CTR_BR_CNT_EN
    check("br_cnt_held", int'(br_cnt), 4);
`endif

    // start while RUN is ignored
    drive(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    check("start_in_run_pc", int'(pc), 2);
    cyc();

    // asynchronous reset mid-run, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", int'(pc), 0);
    check("async_running", int'(running), 0);
    check("async_done", int'(done), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
